wb_stream_writer_cfg_mc: RTL and testbench



---
 rtl/wb_stream_writer_cfg_mc_pkg.sv | 25 ++
 rtl/wb_stream_writer_cfg_mc_if.sv | 27 ++
 rtl/wb_stream_writer_cfg_mc_ch.sv | 88 ++++++++
 rtl/wb_stream_writer_cfg_mc.sv | 90 +++++++++
 tb/tb_wb_stream_writer_cfg_mc.sv | 324 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/wb_stream_writer_cfg_mc_pkg.sv
// Shared register map, CTRL bit positions and width helper for the
// multi-channel stream writer configuration slave.
package wb_stream_writer_pkg;

  localparam logic [2:0] REG_CTRL       = 3'd0;
  localparam logic [2:0] REG_START_ADR  = 3'd1;
  localparam logic [2:0] REG_BUF_SIZE   = 3'd2;
  localparam logic [2:0] REG_BURST_SIZE = 3'd3;
  localparam logic [2:0] REG_BYTE_CNT   = 3'd4;
  localparam logic [2:0] REG_LOOP_CNT   = 3'd5;

  // CTRL read view
  localparam int CTRL_BUSY   = 0;
  localparam int CTRL_IRQ    = 1;
  localparam int CTRL_IRQ_EN = 2;
  localparam int CTRL_CONT   = 3;
  // CTRL write actions sharing the low bits
  localparam int CTRL_START  = 0;
  localparam int CTRL_CLR    = 1;

  function automatic int ch_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/wb_stream_writer_cfg_mc_if.sv
// Wishbone classic slave bundle for the stream writer configuration block.
interface wb_stream_writer_cfg_mc_if #(
  parameter int AW = 6,
  parameter int DW = 32
);
  logic [AW-1:0]   wb_adr_i;
  logic [DW-1:0]   wb_dat_i;
  logic [DW/8-1:0] wb_sel_i;
  logic            wb_we_i;
  logic            wb_cyc_i;
  logic            wb_stb_i;
  logic [2:0]      wb_cti_i;
  logic [1:0]      wb_bte_i;
  logic [DW-1:0]   wb_dat_o;
  logic            wb_ack_o;
  logic            wb_err_o;

  modport master (
    output wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i, wb_cti_i, wb_bte_i,
    input  wb_dat_o, wb_ack_o, wb_err_o
  );

  modport slave (
    input  wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i, wb_cti_i, wb_bte_i,
    output wb_dat_o, wb_ack_o, wb_err_o
  );
endinterface

// File: rtl/wb_stream_writer_cfg_mc_ch.sv
// One channel: config registers, busy fall detect, irq latch, loop counter
// and start / auto-restart pulse generation.
module wb_stream_writer_cfg_ch
  import wb_stream_writer_pkg::*;
#(
  parameter int WB_AW = 32,
  parameter int WB_DW = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [2:0]       reg_sel,
  input  logic [WB_DW-1:0] wr_data,
  output logic [WB_DW-1:0] rd_data,
  input  logic             busy,
  input  logic [WB_DW-1:0] tx_cnt,
  output logic             enable,
  output logic             irq,
  output logic             irq_en,
  output logic [WB_AW-1:0] start_adr,
  output logic [WB_AW-1:0] buf_size,
  output logic [WB_AW-1:0] burst_size
);

  localparam logic [WB_DW-1:0] BYTES_PER_WORD = WB_DW'(WB_DW / 8);

  logic             busy_r;
  logic             done;
  logic             cont;
  logic             ctrl_wr;
  logic             sw_start;
  logic [WB_DW-1:0] loop_cnt;

  assign ctrl_wr  = wr_en && (reg_sel == REG_CTRL);
  assign sw_start = ctrl_wr && wr_data[CTRL_START] && !busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_r     <= 1'b0;
      done       <= 1'b0;
      enable     <= 1'b0;
      irq        <= 1'b0;
      irq_en     <= 1'b0;
      cont       <= 1'b0;
      start_adr  <= '0;
      buf_size   <= '0;
      burst_size <= '0;
      loop_cnt   <= '0;
    end else begin
      busy_r <= busy;
      done   <= busy_r && !busy;
      // restart uses cont as it stood before this edge, so clearing it
      // on the completion edge still lets the finished buffer re-arm once
      enable <= sw_start || (done && cont);
      irq    <= done || (irq && !(ctrl_wr && wr_data[CTRL_CLR]));
      if (ctrl_wr) begin
        irq_en <= wr_data[CTRL_IRQ_EN];
        cont   <= wr_data[CTRL_CONT];
      end
      if (wr_en && (reg_sel == REG_START_ADR))  start_adr  <= WB_AW'(wr_data);
      if (wr_en && (reg_sel == REG_BUF_SIZE))   buf_size   <= WB_AW'(wr_data);
      if (wr_en && (reg_sel == REG_BURST_SIZE)) burst_size <= WB_AW'(wr_data);
      if (wr_en && (reg_sel == REG_LOOP_CNT))
        loop_cnt <= done ? WB_DW'(1) : '0;
      else if (done)
        loop_cnt <= loop_cnt + WB_DW'(1);
    end
  end

  always_comb begin
    rd_data = '0;
    case (reg_sel)
      REG_CTRL: begin
        rd_data[CTRL_BUSY]   = busy;
        rd_data[CTRL_IRQ]    = irq;
        rd_data[CTRL_IRQ_EN] = irq_en;
        rd_data[CTRL_CONT]   = cont;
      end
      REG_START_ADR:  rd_data = WB_DW'(start_adr);
      REG_BUF_SIZE:   rd_data = WB_DW'(buf_size);
      REG_BURST_SIZE: rd_data = WB_DW'(burst_size);
      REG_BYTE_CNT:   rd_data = tx_cnt * BYTES_PER_WORD;
      REG_LOOP_CNT:   rd_data = loop_cnt;
      default:        rd_data = '0;
    endcase
  end

endmodule

// File: rtl/wb_stream_writer_cfg_mc.sv
// Multi-channel stream writer config/status slave: address decode, registered
// ack/err, read mux and per-channel register blocks.
module wb_stream_writer_cfg_mc
  import wb_stream_writer_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int WB_AW  = 32,
  parameter int WB_DW  = 32
) (
  input  logic                    wb_clk_i,
  input  logic                    wb_rst_ni,
  wb_stream_writer_cfg_mc_if.slave wb,
  output logic                    irq,
  output logic [NUM_CH-1:0]       irq_vec,
  input  logic [NUM_CH-1:0]       busy,
  output logic [NUM_CH-1:0]       enable,
  input  logic [NUM_CH*WB_DW-1:0] tx_cnt,
  output logic [NUM_CH*WB_AW-1:0] start_adr,
  output logic [NUM_CH*WB_AW-1:0] buf_size,
  output logic [NUM_CH*WB_AW-1:0] burst_size
);

  localparam int CH_W = ch_w(NUM_CH);

  logic [CH_W-1:0]  ch_sel;
  logic [2:0]       reg_sel;
  logic             ch_ok;
  logic             reg_ok;
  logic             req;
  logic             commit;
  logic             ack_q;
  logic             err_q;
  logic [NUM_CH-1:0] irq_en_vec;
  logic [WB_DW-1:0] rd_vec [NUM_CH];
  logic             unused_ok;

  assign ch_sel  = wb.wb_adr_i[CH_W+4:5];
  assign reg_sel = wb.wb_adr_i[4:2];
  assign reg_ok  = (reg_sel <= REG_LOOP_CNT);

  if (NUM_CH == (1 << CH_W)) begin : g_ch_full
    assign ch_ok = 1'b1;
  end else begin : g_ch_part
    assign ch_ok = (int'(ch_sel) < NUM_CH);
  end

  // the ~ack/~err terms force the idle cycle between responses
  assign req    = wb.wb_cyc_i && wb.wb_stb_i && !ack_q && !err_q;
  assign commit = ack_q && wb.wb_cyc_i && wb.wb_stb_i && wb.wb_we_i;

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      ack_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      ack_q <= req && ch_ok && reg_ok;
      err_q <= req && !(ch_ok && reg_ok);
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    wb_stream_writer_cfg_ch #(
      .WB_AW (WB_AW),
      .WB_DW (WB_DW)
    ) u_ch (
      .clk        (wb_clk_i),
      .rst_n      (wb_rst_ni),
      .wr_en      (commit && (ch_sel == CH_W'(c))),
      .reg_sel    (reg_sel),
      .wr_data    (wb.wb_dat_i),
      .rd_data    (rd_vec[c]),
      .busy       (busy[c]),
      .tx_cnt     (tx_cnt[c*WB_DW +: WB_DW]),
      .enable     (enable[c]),
      .irq        (irq_vec[c]),
      .irq_en     (irq_en_vec[c]),
      .start_adr  (start_adr[c*WB_AW +: WB_AW]),
      .buf_size   (buf_size[c*WB_AW +: WB_AW]),
      .burst_size (burst_size[c*WB_AW +: WB_AW])
    );
  end

  assign wb.wb_dat_o = ch_ok ? rd_vec[ch_sel] : '0;
  assign wb.wb_ack_o = ack_q;
  assign wb.wb_err_o = err_q;
  assign irq         = |(irq_vec & irq_en_vec);

  assign unused_ok = ^{wb.wb_sel_i, wb.wb_cti_i, wb.wb_bte_i, wb.wb_adr_i[1:0]};

endmodule

// File: tb/tb_wb_stream_writer_cfg_mc.sv
// Scoreboard bench for wb_stream_writer_cfg_mc: directed scenarios plus
// randomized register traffic against a behavioural register-map model.
module tb_wb_stream_writer_cfg_mc;
  localparam int NUM_CH = 3;
  localparam int WB_AW  = 32;
  localparam int WB_DW  = 32;
  localparam int CH_W   = 2;
  localparam int AW     = CH_W + 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [NUM_CH-1:0] busy, enable, irq_vec;
  logic irq;
  logic [NUM_CH*WB_DW-1:0] tx_cnt;
  logic [NUM_CH*WB_AW-1:0] start_adr, buf_size, burst_size;

  wb_stream_writer_cfg_mc_if #(.AW(AW), .DW(WB_DW)) wb ();

  wb_stream_writer_cfg_mc #(.NUM_CH(NUM_CH), .WB_AW(WB_AW), .WB_DW(WB_DW)) dut (
    .wb_clk_i   (clk),
    .wb_rst_ni  (rst_n),
    .wb         (wb),
    .irq        (irq),
    .irq_vec    (irq_vec),
    .busy       (busy),
    .enable     (enable),
    .tx_cnt     (tx_cnt),
    .start_adr  (start_adr),
    .buf_size   (buf_size),
    .burst_size (burst_size)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_err;
    bit          chk;
    logic [31:0] data;
    int          ch;
    int          rg;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int n_tests = 0;
  int n_fail  = 0;

  // behavioural register map
  logic [31:0] m_adr [NUM_CH];
  logic [31:0] m_size[NUM_CH];
  logic [31:0] m_burst[NUM_CH];
  logic [31:0] m_loop[NUM_CH];
  logic [31:0] m_tx  [NUM_CH];
  logic [NUM_CH-1:0] m_irq, m_irq_en, m_cont;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < NUM_CH; c++) begin
      m_adr[c] = 0; m_size[c] = 0; m_burst[c] = 0; m_loop[c] = 0;
    end
    m_irq = '0; m_irq_en = '0; m_cont = '0;
  endtask

  function automatic logic [31:0] rd_exp(input int ch, input int rg);
    if (ch >= NUM_CH) return 32'd0;
    case (rg)
      0: return {28'd0, m_cont[ch], m_irq_en[ch], m_irq[ch], busy[ch]};
      1: return m_adr[ch];
      2: return m_size[ch];
      3: return m_burst[ch];
      4: return m_tx[ch] * 4;
      5: return m_loop[ch];
      default: return 32'd0;
    endcase
  endfunction

  function automatic bit irq_exp();
    bit r = 1'b0;
    for (int c = 0; c < NUM_CH; c++) if (m_irq[c] && m_irq_en[c]) r = 1'b1;
    return r;
  endfunction

  task automatic check_ports();
    for (int c = 0; c < NUM_CH; c++) begin
      check($sformatf("start_adr%0d", c), start_adr[c*WB_AW +: WB_AW], m_adr[c]);
      check($sformatf("buf_size%0d", c), buf_size[c*WB_AW +: WB_AW], m_size[c]);
      check($sformatf("burst_size%0d", c), burst_size[c*WB_AW +: WB_AW], m_burst[c]);
    end
    check("irq_vec", irq_vec, m_irq);
    check("irq", irq, irq_exp());
  endtask

  // monitor: pops one expectation per response
  always @(negedge clk) begin
    if (rst_n && (wb.wb_ack_o || wb.wb_err_o)) begin
      if (sbq.size() == 0) begin
        check("unexpected_resp", 1, 0);
      end else begin
        mon_e = sbq.pop_front();
        check($sformatf("resp_err ch%0d r%0d", mon_e.ch, mon_e.rg), wb.wb_err_o, mon_e.is_err);
        check($sformatf("resp_ack ch%0d r%0d", mon_e.ch, mon_e.rg), wb.wb_ack_o, !mon_e.is_err);
        if (mon_e.chk)
          check($sformatf("rdata ch%0d r%0d", mon_e.ch, mon_e.rg), wb.wb_dat_o, mon_e.data);
      end
    end
  end

  task automatic wb_xfer(input int ch, input int rg, input bit we, input logic [31:0] d,
                         input int drop_ch = -1);
    exp_t e;
    bit ok;
    int t;
    logic [NUM_CH-1:0] exp_en;
    ok = (ch < NUM_CH) && (rg < 6);
    e.is_err = !ok;
    e.chk    = !we || !ok;
    e.data   = (ok && !we) ? rd_exp(ch, rg) : 32'd0;
    e.ch     = ch;
    e.rg     = rg;
    sbq.push_back(e);
    wb.wb_adr_i = {ch[CH_W-1:0], rg[2:0], 2'b00};
    wb.wb_dat_i = d;
    wb.wb_we_i  = we;
    wb.wb_cyc_i = 1'b1;
    wb.wb_stb_i = 1'b1;
    if (drop_ch >= 0) busy[drop_ch] = 1'b0;
    for (t = 0; t < 8; t++) begin
      @(posedge clk); #1;
      if (wb.wb_ack_o || wb.wb_err_o) break;
    end
    if (t == 8) begin
      check("resp_timeout", 0, 1);
      if (sbq.size() > 0) e = sbq.pop_front();
      wb.wb_cyc_i = 1'b0; wb.wb_stb_i = 1'b0; wb.wb_we_i = 1'b0;
      return;
    end
    check("resp_latency", t, 0);
    @(posedge clk); #1;
    wb.wb_cyc_i = 1'b0; wb.wb_stb_i = 1'b0; wb.wb_we_i = 1'b0;
    check("resp_one_cycle", {wb.wb_ack_o, wb.wb_err_o}, 0);
    exp_en = '0;
    if (drop_ch >= 0) exp_en[drop_ch] = m_cont[drop_ch];
    if (ok && we) begin
      case (rg)
        0: begin
          if (d[0] && !busy[ch]) exp_en[ch] = 1'b1;
          if (d[1]) m_irq[ch] = 1'b0;
          m_irq_en[ch] = d[2];
          m_cont[ch]   = d[3];
        end
        1: m_adr[ch]   = d;
        2: m_size[ch]  = d;
        3: m_burst[ch] = d;
        5: m_loop[ch]  = 0;
        default: ;
      endcase
    end
    if (drop_ch >= 0) begin
      m_irq[drop_ch]  = 1'b1;
      m_loop[drop_ch] = m_loop[drop_ch] + 1;
    end
    check($sformatf("enable after ch%0d r%0d", ch, rg), enable, exp_en);
    check_ports();
  endtask

  task automatic busy_finish(input int ch);
    logic [NUM_CH-1:0] exp_en = '0;
    busy[ch] = 1'b0;
    @(posedge clk); #1;
    check("enable_early", enable, 0);
    check("irq_vec_early", irq_vec, m_irq);
    @(posedge clk); #1;
    exp_en[ch] = m_cont[ch];
    m_irq[ch]  = 1'b1;
    m_loop[ch] = m_loop[ch] + 1;
    check($sformatf("restart_en ch%0d", ch), enable, exp_en);
    check_ports();
    @(posedge clk); #1;
    check("enable_one_cycle", enable, 0);
  endtask

  task automatic busy_pulse(input int ch, input int n);
    busy[ch] = 1'b1;
    repeat (n) @(posedge clk);
    #1;
    busy_finish(ch);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    exp_t e;
    int ch, rg, op;
    logic [31:0] v;
    busy = '0;
    tx_cnt = '0;
    for (int c = 0; c < NUM_CH; c++) m_tx[c] = 0;
    wb.wb_adr_i = '0; wb.wb_dat_i = '0; wb.wb_sel_i = '1; wb.wb_we_i = 1'b0;
    wb.wb_cyc_i = 1'b0; wb.wb_stb_i = 1'b0; wb.wb_cti_i = '0; wb.wb_bte_i = '0;
    model_reset();

    #1;
    check("rst_ack", wb.wb_ack_o, 0);
    check("rst_err", wb.wb_err_o, 0);
    check("rst_enable", enable, 0);
    check_ports();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    for (int c = 0; c < 2; c++)
      for (int r = 0; r < 8; r++) wb_xfer(c, r, 1'b0, 32'd0);

    wb_xfer(1, 1, 1'b1, 32'h1000_0000);
    wb_xfer(1, 2, 1'b1, 32'h0000_0400);
    wb_xfer(1, 3, 1'b1, 32'h0000_0040);
    for (int r = 1; r < 4; r++) wb_xfer(1, r, 1'b0, 32'd0);

    wb_xfer(0, 0, 1'b1, 32'h5);
    busy_pulse(0, 10);
    wb_xfer(0, 5, 1'b0, 32'd0);
    wb_xfer(0, 0, 1'b1, 32'h2);

    // continuous mode, three buffers
    wb_xfer(0, 0, 1'b1, 32'hC);
    wb_xfer(0, 5, 1'b1, 32'd0);
    for (int i = 0; i < 3; i++) busy_pulse(0, 3 + i);
    wb_xfer(0, 5, 1'b0, 32'd0);
    // clear-irq lands on the same edge as the completion
    busy[0] = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    wb_xfer(0, 0, 1'b1, 32'hE, 0);
    @(posedge clk); #1;
    check("collide_enable_gone", enable, 0);
    wb_xfer(0, 0, 1'b0, 32'd0);

    // start while busy is ignored
    busy[1] = 1'b1;
    wb_xfer(1, 0, 1'b1, 32'h1);
    busy_finish(1);

    // errors and byte count
    wb_xfer(3, 1, 1'b1, 32'hDEAD_BEEF);
    wb_xfer(3, 0, 1'b1, 32'h1);
    wb_xfer(3, 1, 1'b0, 32'd0);
    wb_xfer(0, 6, 1'b1, 32'h1);
    wb_xfer(2, 7, 1'b0, 32'd0);
    tx_cnt[0 +: WB_DW] = 32'h4000_0001; m_tx[0] = 32'h4000_0001;
    wb_xfer(0, 4, 1'b0, 32'd0);
    wb_xfer(0, 4, 1'b1, 32'h1234);
    wb_xfer(0, 4, 1'b0, 32'd0);

    for (int i = 0; i < 80; i++) begin
      ch = $urandom_range(0, 3);
      rg = $urandom_range(0, 7);
      op = $urandom_range(0, 6);
      v  = $urandom;
      case (op)
        0, 1: wb_xfer(ch, rg, 1'b0, 32'd0);
        2:    wb_xfer(ch, rg, 1'b1, v);
        3:    wb_xfer(ch, 0, 1'b1, v & 32'hF);
        4:    busy_pulse(ch % NUM_CH, $urandom_range(1, 5));
        5: begin
          tx_cnt[(ch % NUM_CH)*WB_DW +: WB_DW] = v;
          m_tx[ch % NUM_CH] = v;
          wb_xfer(ch % NUM_CH, 4, 1'b0, 32'd0);
        end
        default: wb_xfer(ch, 5, 1'b1, v);
      endcase
    end

    // async reset in the middle of a transfer with continuous mode active
    wb_xfer(0, 0, 1'b1, 32'hC);
    wb_xfer(1, 1, 1'b1, 32'hCAFE_0000);
    busy[0] = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    e.is_err = 1'b0; e.chk = 1'b0; e.data = 32'd0; e.ch = 1; e.rg = 1;
    sbq.push_back(e);
    wb.wb_adr_i = {2'd1, 3'd1, 2'b00};
    wb.wb_dat_i = 32'h55;
    wb.wb_we_i  = 1'b1;
    wb.wb_cyc_i = 1'b1;
    wb.wb_stb_i = 1'b1;
    @(posedge clk); #1;
    check("ack_before_reset", wb.wb_ack_o, 1);
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("async_rst_ack", wb.wb_ack_o, 0);
    check("async_rst_err", wb.wb_err_o, 0);
    check("async_rst_enable", enable, 0);
    check_ports();
    wb.wb_cyc_i = 1'b0; wb.wb_stb_i = 1'b0; wb.wb_we_i = 1'b0;
    busy = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      check("no_enable_after_reset", enable, 0);
    end
    wb_xfer(1, 1, 1'b0, 32'd0);
    wb_xfer(0, 0, 1'b0, 32'd0);

    repeat (2) @(posedge clk);
    check("scoreboard_empty", sbq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
